alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU; consumes the 4-bit ALUCtrl code from the ALU control decoder and produces BusW.
//  Single-cycle ops are registered: 1-cycle latency. Code 4'b0101 (MULA) runs an iterative
//  unsigned multiply-accumulate into HI/LO. A start/busy/done handshake lets the pipeline
//  controller stall on multi-cycle ops.
// PARAMETERS
//  WIDTH          32  datapath width (BusA, BusB, BusW, Hi, Lo)
//  MUL_BITS       1   multiplier bits retired per MULA cycle; must divide WIDTH
// PORTS
//  Clk       in   1      clock, all state on rising edge
//  Reset     in   1      synchronous, active-high reset
//  start     in   1      launch op; sampled only when busy=0
//  ALUCtrl   in   4      op code (encoding below)
//  BusA      in   WIDTH  operand A (rs)
//  BusB      in   WIDTH  operand B (rt / imm)
//  shamt     in   5      shift amount for SLL/SRL/SRA
//  HiLoClr   in   1      clear Hi/Lo; honoured only when busy=0
//  busy      out  1      MULA in progress
//  done      out  1      one-cycle pulse: BusW/Zero/Overflow/Illegal valid
//  BusW      out  WIDTH  result, held until next done
//  Zero      out  1      BusW==0, updated with BusW
//  Overflow  out  1      signed overflow, ADD/SUB only
//  Illegal   out  1      unsupported ALUCtrl code
//  Hi, Lo    out  WIDTH  accumulator halves
// BEHAVIOUR
//  Reset: busy=0, done=0, BusW=0, Zero=0, Overflow=0, Illegal=0, Hi=0, Lo=0, FSM=IDLE.
//  Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SRL, 0101 MULA, 0110 SUB, 0111 SLT,
//   1000 ADDU, 1001 SUBU, 1010 XOR, 1011 SLTU, 1100 NOR, 1101 SRA, 1110 LUI, 1111 illegal.
//  Shifts act on BusB by shamt; LUI = {BusB[15:0],16'b0}; SLT signed, SLTU unsigned, result 0/1.
//  ADD/SUB: wrapped result written, Overflow=1 on signed overflow; all other ops Overflow=0.
//  Illegal code: BusW=0, Zero=1, Illegal=1, done pulses at latency 1; Illegal=0 otherwise.
//  FSM IDLE: start=1 & single-cycle op -> result registered, done=1 next cycle, stay IDLE.
//   start=1 & MULA -> latch BusA/BusB, clear product, busy=1 next cycle, go MUL.
//  FSM MUL: WIDTH/MUL_BITS iterations of shift-add; on the cycle after the last iteration:
//   {Hi,Lo} <= {Hi,Lo} + BusA*BusB (unsigned, mod 2^(2*WIDTH)), BusW=new Lo, Zero per BusW,
//   done=1, busy=0, go IDLE. Latency start->done = WIDTH/MUL_BITS + 1 (33 at defaults).
//  start while busy=1: ignored, no effect on operands or result.
//  start on the done cycle of a MULA (busy already 0): accepted (back-to-back).
//  HiLoClr with start=1 & MULA same cycle: clear first, accumulate into zero.
//  HiLoClr while busy=1: ignored. Single-cycle ops never modify Hi/Lo.
//  Reset mid-MULA: aborts, no done pulse, all outputs to reset values.
// CONFIGURATION
//  ALU_MULA_EN defined: MULA supported as above.
//  ALU_MULA_EN undefined: code 0101 treated as illegal (latency 1, Illegal=1); no MUL state,
//   busy tied 0, Hi/Lo still cleared by Reset/HiLoClr but never otherwise written.
// TESTING
//  ADD 0x7FFFFFFF+1 -> done at +1 cycle, BusW=0x80000000, Overflow=1, Zero=0.
//  SUB 5-5 -> BusW=0, Zero=1; SLT -1,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0; SRA 0x80000000 shamt 4 -> 0xF8000000.
//  MULA 0xFFFFFFFF*0xFFFFFFFF from Hi/Lo=0 -> busy 32 cycles, done at +33, Hi=0xFFFFFFFE, Lo=1.
//  Second MULA 2*3 started on done cycle -> Lo=7, Hi=0xFFFFFFFE; start pulses mid-busy ignored.
//  Reset asserted at cycle 10 of MULA -> no done, busy=0, Hi=Lo=0; then AND 0xF0,0x3C -> 0x30.
//  ALUCtrl=1111 -> BusW=0, Illegal=1; without ALU_MULA_EN, 0101 -> Illegal=1, busy never 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered results and iterative MULA.
// Define ALU_MULA_EN to enable the multiply-accumulate path (code 0101).
module alu_exec_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [4:0]       shamt,
  input  logic             HiLoClr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_ADDU = 4'b1000;
  localparam logic [3:0] OP_SUBU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b1110;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             ill;
  logic             single;
  logic             clr;

  always_comb begin
    sum = BusA + BusB;
    dif = BusA - BusB;
    res = '0;
    ovf = 1'b0;
    ill = 1'b0;
    unique case (ALUCtrl)
      OP_AND:  res = BusA & BusB;
      OP_OR:   res = BusA | BusB;
      OP_ADD: begin
        res = sum;
        ovf = (BusA[WIDTH-1] == BusB[WIDTH-1]) &&
              (sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SLL:  res = BusB << shamt;
      OP_SRL:  res = BusB >> shamt;
      OP_SUB: begin
        res = dif;
        ovf = (BusA[WIDTH-1] != BusB[WIDTH-1]) &&
              (dif[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(BusA) < $signed(BusB)};
      OP_ADDU: res = sum;
      OP_SUBU: res = dif;
      OP_XOR:  res = BusA ^ BusB;
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, BusA < BusB};
      OP_NOR:  res = ~(BusA | BusB);
      OP_SRA:  res = $signed(BusB) >>> shamt;
      OP_LUI:  res = {BusB[15:0], {(WIDTH-16){1'b0}}};
      default: ill = 1'b1;
    endcase
  end

`ifdef ALU_MULA_EN
  localparam logic [3:0] OP_MULA = 4'b0101;
  localparam int N  = WIDTH / MUL_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  state_t             state_n;
  logic               launch;
  logic               finish;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod_n;
  logic [2*WIDTH-1:0] acc;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    finish  = 1'b0;
    single  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && ALUCtrl == OP_MULA) begin
          launch  = 1'b1;
          state_n = MUL;
        end else if (start) begin
          single = 1'b1;
        end
      end
      MUL: begin
        if (cnt == LAST) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end

  assign busy = (state == MUL);
  assign clr  = HiLoClr && !busy;

  // Last step's partial sum is folded straight into the accumulator.
  always_comb begin
    step = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplr[i]) step = step + (mcand << i);
    end
    prod_n = prod + step;
    acc    = {Hi, Lo} + prod_n;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt   <= '0;
      mplr  <= '0;
      mcand <= '0;
      prod  <= '0;
    end else if (launch) begin
      cnt   <= '0;
      mplr  <= BusB;
      mcand <= {{WIDTH{1'b0}}, BusA};
      prod  <= '0;
    end else if (busy) begin
      cnt   <= cnt + CW'(1);
      mplr  <= mplr >> MUL_BITS;
      mcand <= mcand << MUL_BITS;
      prod  <= prod_n;
    end
  end
`else
  assign single = start;
  assign busy   = 1'b0;
  assign clr    = HiLoClr;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      done     <= 1'b0;
      BusW     <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      Illegal  <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        Hi <= '0;
        Lo <= '0;
      end
      if (single) begin
        done     <= 1'b1;
        BusW     <= res;
        Zero     <= (res == '0);
        Overflow <= ovf;
        Illegal  <= ill;
      end
`ifdef ALU_MULA_EN
      if (finish) begin
        {Hi, Lo} <= acc;
        done     <= 1'b1;
        BusW     <= acc[WIDTH-1:0];
        Zero     <= (acc[WIDTH-1:0] == '0);
        Overflow <= 1'b0;
        Illegal  <= 1'b0;
      end
`endif
    end
  end

endmodule
